// File: rtl/instr_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_responder_if
//  Description : Fetch and program-port bundle between the CPU fetch stage
//                (master) and the instruction memory responder (slave).
//                  PC           32  byte address of the requested instruction
//                  READ          1  fetch request, level-sensitive
//                  PROG_WE       1  program-port word write enable
//                  PROG_ADDR    32  program-port byte address
//                  PROG_DATA    32  program-port write word
//                  INSTRUCTIONS 32  fetched instruction word
//                  BUSYWAIT      1  fetch stage must stall
//  Revision    : 1.0  initial release
// ============================================================================
interface instr_mem_responder_if;
    logic [31:0] PC;
    logic        READ;
    logic        PROG_WE;
    logic [31:0] PROG_ADDR;
    logic [31:0] PROG_DATA;
    logic [31:0] INSTRUCTIONS;
    logic        BUSYWAIT;

    modport master (
        output PC, READ, PROG_WE, PROG_ADDR, PROG_DATA,
        input  INSTRUCTIONS, BUSYWAIT
    );

    modport slave (
        input  PC, READ, PROG_WE, PROG_ADDR, PROG_DATA,
        output INSTRUCTIONS, BUSYWAIT
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem_responder
//  Description : Instruction-fetch memory responder. A miss stalls the CPU
//                for LATENCY+1 cycles (request cycle plus LATENCY fetch
//                cycles) and then presents the word for one DONE cycle. A
//                one-entry last-fetch buffer answers repeat reads of the same
//                word with no stall. A word-write program port loads the
//                array in any state.
//  Ports       : CLK    clock, rising edge
//                RESET  asynchronous reset, active low
//                bus    instr_mem_responder_if.slave (fetch + program port)
//  Parameters  : ADDR_W   byte-address bits used (array = 2**ADDR_W bytes)
//                LATENCY  fetch cycles per miss, 1..15
//  Revision    : 1.0  initial release
// ============================================================================
module instr_mem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    instr_mem_responder_if.slave   bus
);

    localparam int          c_IDX_W    = ADDR_W - 2;
    localparam int          c_DEPTH    = 1 << c_IDX_W;
    localparam logic [3:0]  c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [3:0]           r_cnt;
    logic [c_IDX_W-1:0]   r_last_idx;
    logic                 r_valid;
    logic [31:0]          r_instr;
    logic [31:0]          r_mem [c_DEPTH];

    logic [c_IDX_W-1:0]   w_pc_idx;
    logic [c_IDX_W-1:0]   w_prog_idx;
    logic                 w_hit;
    logic                 w_busy;
    logic                 w_unused;

    // Word index only: byte offset and address bits above the array wrap.
    assign w_pc_idx   = bus.PC[ADDR_W-1:2];
    assign w_prog_idx = bus.PROG_ADDR[ADDR_W-1:2];
    assign w_unused   = &{1'b0, bus.PC[31:ADDR_W], bus.PC[1:0],
                          bus.PROG_ADDR[31:ADDR_W], bus.PROG_ADDR[1:0]};

    assign w_hit = r_valid && (w_pc_idx == r_last_idx);

    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            S_IDLE:  w_busy = bus.READ && !w_hit;
            S_FETCH: w_busy = 1'b1;
            default: w_busy = 1'b0;
        endcase
    end

    // Reset must drop the stall immediately, even with READ held high.
    assign bus.BUSYWAIT     = RESET && w_busy;
    assign bus.INSTRUCTIONS = r_instr;

    // Array contents survive reset, so it has no reset term.
    always_ff @(posedge CLK) begin
        if (bus.PROG_WE) begin
            r_mem[w_prog_idx] <= bus.PROG_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_last_idx <= '0;
            r_valid    <= 1'b0;
            r_instr    <= 32'h0000_0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.READ && !w_hit) begin
                        r_last_idx <= w_pc_idx;
                        r_cnt      <= c_CNT_INIT;
                        r_valid    <= 1'b0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // PC and READ are not looked at here: the latched index
                    // always completes.
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_instr <= r_mem[r_last_idx];
                        r_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A write to the buffered word invalidates it. Placed last so it
            // wins over a same-edge fetch completion; that completion still
            // captures the pre-write word.
            if (bus.PROG_WE && (w_prog_idx == r_last_idx)) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_mem_responder
//  Description : Scoreboard bench for instr_mem_responder. Each fetch request
//                pushes the expected word and stall length into a queue; a
//                monitor pops and compares whenever the responder accepts a
//                request (READ high, BUSYWAIT low).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_mem_responder;

    localparam int c_ADDR_W = 10;
    localparam int c_LAT    = 4;
    localparam int c_IDX_W  = c_ADDR_W - 2;
    localparam int c_WORDS  = 1 << c_IDX_W;

    typedef struct {
        logic [31:0] data;
        int          stall;
    } exp_t;

    logic CLK;
    logic RESET;

    instr_mem_responder_if bus ();

    instr_mem_responder #(
        .ADDR_W  (c_ADDR_W),
        .LATENCY (c_LAT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: word array plus a one-word "last fetched" record.
    logic [31:0] m_mem [c_WORDS];
    int          m_idx;
    bit          m_valid;

    exp_t        q [$];
    int          n_checks;
    int          n_errors;
    int          stall;

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[c_ADDR_W-1:2]);
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // A read either hits the recorded word (no stall) or misses, costing the
    // request cycle plus the fetch cycles, and becomes the recorded word.
    function automatic exp_t model_fetch(input int idx);
        exp_t e;
        e.data = m_mem[idx];
        if (m_valid && (idx == m_idx)) begin
            e.stall = 0;
        end else begin
            e.stall = c_LAT + 1;
            m_idx   = idx;
            m_valid = 1'b1;
        end
        return e;
    endfunction

    // Fetch from pc. inj_k >= 0 writes inj_d to the same word during fetch
    // cycle inj_k of a miss; chg swaps PC to pc2 in the second fetch cycle.
    task automatic fetch(input logic [31:0] pc, input int inj_k,
                         input logic [31:0] inj_d, input bit chg,
                         input logic [31:0] pc2);
        exp_t e;
        int   idx;
        int   c;
        bit   inj;
        idx = idx_of(pc);
        e   = model_fetch(idx);
        inj = (e.stall != 0) && (inj_k >= 0);
        if (inj) begin
            // Write landing on the completing edge is too late to be seen
            // and leaves the word unbuffered; earlier writes are returned.
            if (inj_k == c_LAT - 1) m_valid = 1'b0;
            else                    e.data  = inj_d;
            m_mem[idx] = inj_d;
        end
        q.push_back(e);
        bus.PC   = pc;
        bus.READ = 1'b1;
        c = 0;
        forever begin
            @(negedge CLK);
            if (!bus.BUSYWAIT) break;
            if (c >= 64) begin
                n_checks++;
                n_errors++;
                $display("FAIL busywait_timeout: got %0d stall cycles expected %0d", c, e.stall);
                break;
            end
            @(posedge CLK);
            #1;
            c++;
            bus.PROG_WE   = inj && (c == inj_k + 1);
            bus.PROG_ADDR = pc;
            bus.PROG_DATA = inj_d;
            if (chg && (c == 2)) bus.PC = pc2;
        end
        @(posedge CLK);
        #1;
        bus.READ    = 1'b0;
        bus.PROG_WE = 1'b0;
    endtask

    // One program-port write; optionally with a simultaneous hitting read.
    task automatic prog(input logic [31:0] addr, input logic [31:0] data,
                        input bit with_read, input logic [31:0] rpc);
        int idx;
        idx = idx_of(addr);
        if (with_read) begin
            q.push_back(model_fetch(idx_of(rpc)));
            bus.PC   = rpc;
            bus.READ = 1'b1;
        end else begin
            bus.READ = 1'b0;
        end
        bus.PROG_WE   = 1'b1;
        bus.PROG_ADDR = addr;
        bus.PROG_DATA = data;
        @(posedge CLK);
        #1;
        bus.PROG_WE = 1'b0;
        bus.READ    = 1'b0;
        m_mem[idx] = data;
        if (m_valid && (m_idx == idx)) m_valid = 1'b0;
    endtask

    task automatic reset_mid_fetch();
        logic [31:0] pc;
        pc = 32'((((m_idx + 3) % c_WORDS)) * 4);
        bus.PC   = pc;
        bus.READ = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        chk("midfetch_reset_instr", bus.INSTRUCTIONS, 32'h0);
        chk("midfetch_reset_busy", {31'b0, bus.BUSYWAIT}, 32'h0);
        m_valid = 1'b0;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        fetch(pc, -1, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] pc;
        logic [31:0] d;
        int          op;

        n_checks = 0;
        n_errors = 0;
        stall    = 0;
        m_idx    = 0;
        m_valid  = 1'b0;
        RESET         = 1'b0;
        bus.PC        = 32'h0;
        bus.READ      = 1'b1;
        bus.PROG_WE   = 1'b0;
        bus.PROG_ADDR = 32'h0;
        bus.PROG_DATA = 32'h0;

        fork
            begin : monitor
                forever begin
                    @(negedge CLK);
                    if (!RESET) begin
                        stall = 0;
                    end else if (bus.READ) begin
                        if (bus.BUSYWAIT) begin
                            stall++;
                        end else begin
                            if (q.size() == 0) begin
                                n_checks++;
                                n_errors++;
                                $display("FAIL unexpected_accept: got accept with no request pending at %0t", $time);
                            end else begin
                                e = q.pop_front();
                                chk("fetch_data", bus.INSTRUCTIONS, e.data);
                                chk("fetch_stall", 32'(stall), 32'(e.stall));
                            end
                            stall = 0;
                        end
                    end
                end
            end
            begin : watchdog
                #2000000;
                $display("FAIL global_timeout: got no finish expected finish");
                $fatal(1, "bench timeout");
            end
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_instr", bus.INSTRUCTIONS, 32'h0);
        chk("reset_busy_read_high", {31'b0, bus.BUSYWAIT}, 32'h0);
        RESET    = 1'b1;
        bus.READ = 1'b0;

        for (int i = 0; i < c_WORDS; i++) begin
            d = (i == 0) ? 32'h0501_0007 : $urandom();
            prog(32'(i * 4), d, 1'b0, 32'h0);
        end

        // Miss then repeated hits, including aliased and unaligned PCs.
        fetch(32'h0000_0000, -1, 32'h0, 1'b0, 32'h0);
        repeat (3) fetch(32'h0000_0000, -1, 32'h0, 1'b0, 32'h0);
        fetch(32'h0000_0400, -1, 32'h0, 1'b0, 32'h0);
        fetch(32'h0000_0002, -1, 32'h0, 1'b0, 32'h0);

        // Overwrite the buffered word during a hit; next read misses.
        prog(32'h0, 32'h0, 1'b1, 32'h0);
        fetch(32'h0000_0000, -1, 32'h0, 1'b0, 32'h0);

        // PC moves mid-fetch; the latched word returns, then the new PC misses.
        fetch(32'h0000_0004, -1, 32'h0, 1'b1, 32'h0000_0008);
        fetch(32'h0000_0008, -1, 32'h0, 1'b0, 32'h0);

        // Writes to the word being fetched, at the completing edge and earlier.
        fetch(32'h0000_0010, c_LAT - 1, 32'hDEAD_BEEF, 1'b0, 32'h0);
        fetch(32'h0000_0010, -1, 32'h0, 1'b0, 32'h0);
        fetch(32'h0000_0020, 0, 32'hCAFE_F00D, 1'b0, 32'h0);
        fetch(32'h0000_0020, -1, 32'h0, 1'b0, 32'h0);

        reset_mid_fetch();

        for (int t = 0; t < 400; t++) begin
            op = int'($urandom_range(0, 99));
            pc = $urandom();
            if (m_valid && ($urandom_range(0, 2) == 0)) pc[c_ADDR_W-1:2] = c_IDX_W'(m_idx);
            if (op < 50) begin
                fetch(pc, -1, 32'h0, 1'b0, 32'h0);
            end else if (op < 65) begin
                fetch(pc, int'($urandom_range(0, c_LAT - 1)), $urandom(), 1'b0, 32'h0);
            end else if (op < 75) begin
                fetch(pc, -1, 32'h0, 1'b1, $urandom());
            end else if (op < 92) begin
                if (m_valid && ($urandom_range(0, 1) == 0))
                    prog(pc, $urandom(), 1'b1, 32'(m_idx * 4) | ($urandom() & 32'hFFFF_FC03));
                else
                    prog(pc, $urandom(), 1'b0, 32'h0);
            end else if (op < 97) begin
                repeat ($urandom_range(1, 3)) @(posedge CLK);
                #1;
            end else begin
                reset_mid_fetch();
            end
        end

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
